// File: rtl/delta_pkg.sv
// Shared widths, types and direction encoding for the delta step counter.
package delta_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DELTA_W = 3;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [DELTA_W-1:0] delta_t;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/delta_step_calc.sv
// Combinational next-state for the delta counter.
// DELTA_BOUNCE_EN: bounce between 0 and CNT_MAX with a direction input/output;
// otherwise plain modulo 2**CNT_W wrap with no direction ports.
module delta_step_calc
  import delta_pkg::*;
(
  input  cnt_t   cnt,
  input  delta_t delta,
`ifdef DELTA_BOUNCE_EN
  input  dir_e   dir,
  output dir_e   dir_nxt,
`endif
  output cnt_t   cnt_nxt
);

  logic [CNT_W:0] sum;
`ifdef DELTA_BOUNCE_EN
  localparam logic [CNT_W:0] TWO_MAX = {CNT_MAX, 1'b0};
  logic [CNT_W:0]          refl;
  logic signed [CNT_W+1:0] diff;
  logic signed [CNT_W+1:0] neg;
`endif

  // Compute the stepped value; the top of sum is the discarded carry in wrap mode
  always_comb begin
    sum = {1'b0, cnt} + {{(CNT_W+1-DELTA_W){1'b0}}, delta};
`ifdef DELTA_BOUNCE_EN
    refl    = TWO_MAX - sum;
    diff    = $signed({2'b00, cnt}) - $signed({{(CNT_W+2-DELTA_W){1'b0}}, delta});
    neg     = -diff;
    cnt_nxt = cnt;
    dir_nxt = dir;
    // delta=0 must hold both count and direction, so skip reflection entirely
    if (delta != '0) begin
      if (dir == DIR_UP) begin
        if (sum < {1'b0, CNT_MAX}) begin
          cnt_nxt = cnt_t'(sum);
        end else begin
          cnt_nxt = cnt_t'(refl);
          dir_nxt = DIR_DOWN;
        end
      end else begin
        if (diff > 0) begin
          cnt_nxt = cnt_t'(diff);
        end else begin
          cnt_nxt = cnt_t'(neg);
          dir_nxt = DIR_UP;
        end
      end
    end
`else
    cnt_nxt = cnt_t'(sum);
`endif
  end

endmodule

// File: rtl/delta_counter.sv
// Registered step counter: count advances by delta on every rising edge.
// Synchronous active-high reset on port resetn.
// Define DELTA_BOUNCE_EN for ladder mode (bounce 0..max with a dir flop);
// default build wraps modulo 2**CNT_W.
module delta_counter
  import delta_pkg::*;
#(
  parameter int unsigned CNT_W   = delta_pkg::CNT_W,
  parameter int unsigned DELTA_W = delta_pkg::DELTA_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [DELTA_W-1:0] delta,
  output logic [CNT_W-1:0]   count
);

  // Reflection is single-bounce only, so the largest step may not exceed CNT_MAX
  if (((2**DELTA_W) - 1) > ((2**CNT_W) - 1)) begin : g_bad_delta_w
    $error("delta_counter: 2**DELTA_W-1 exceeds CNT_MAX");
  end
  if ((CNT_W != delta_pkg::CNT_W) || (DELTA_W != delta_pkg::DELTA_W)) begin : g_bad_pkg_w
    $error("delta_counter: parameters must match delta_pkg widths");
  end

  cnt_t cnt_nxt;

`ifdef DELTA_BOUNCE_EN
  dir_e dir;
  dir_e dir_nxt;

  delta_step_calc u_calc (
    .cnt     (count),
    .delta   (delta),
    .dir     (dir),
    .dir_nxt (dir_nxt),
    .cnt_nxt (cnt_nxt)
  );

  // Count and direction registers; reset wins over the step
  always_ff @(posedge clk) begin
    if (resetn) begin
      count <= '0;
      dir   <= DIR_UP;
    end else begin
      count <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end
`else
  delta_step_calc u_calc (
    .cnt     (count),
    .delta   (delta),
    .cnt_nxt (cnt_nxt)
  );

  // Count register; reset wins over the step
  always_ff @(posedge clk) begin
    if (resetn) begin
      count <= '0;
    end else begin
      count <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_delta_counter.sv
// Directed self-checking bench for delta_counter.
// Checks the wrap sequences by default, or the bounce sequences when DELTA_BOUNCE_EN is defined.
module tb_delta_counter;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [2:0] delta = '0;
  logic [3:0] count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  delta_counter #(.CNT_W(4), .DELTA_W(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .delta  (delta),
    .count  (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    n_total++;
    assert (count === exp) n_pass++;
    else $error("FAIL %s: count=%0d expected %0d", tag, count, exp);
  endtask

  // Apply delta for one edge, then check count just after that edge
  task automatic step(input string tag, input logic [2:0] d, input logic [3:0] exp);
    delta = d;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b1;
    delta  = 3'd5;
    @(posedge clk);
    #1;
    check(tag, 4'd0);
    resetn = 1'b0;
  endtask

  initial begin
    do_reset("reset");
`ifndef DELTA_BOUNCE_EN
    // delta=3 from reset, wrapping past 15
    step("w3_a", 3'd3, 4'd3);
    step("w3_b", 3'd3, 4'd6);
    step("w3_c", 3'd3, 4'd9);
    step("w3_d", 3'd3, 4'd12);
    step("w3_e", 3'd3, 4'd15);
    step("w3_wrap", 3'd3, 4'd2);
    // delta=7 from count=2
    step("w7_a", 3'd7, 4'd9);
    step("w7_wrap", 3'd7, 4'd0);
    step("w7_b", 3'd7, 4'd7);
    step("w7_c", 3'd7, 4'd14);
    step("w7_wrap2", 3'd7, 4'd5);
    // delta=0 holds for 10 edges
    for (int i = 0; i < 10; i++) step("hold", 3'd0, 4'd5);
    // reach 9 with delta=2, then reset mid-run
    step("d2_a", 3'd2, 4'd7);
    step("d2_b", 3'd2, 4'd9);
    do_reset("mid_reset");
    step("after_reset", 3'd2, 4'd2);
    // delta changes every cycle
    step("chg_3", 3'd3, 4'd5);
    step("chg_2", 3'd2, 4'd7);
    step("chg_7", 3'd7, 4'd14);
    step("chg_0", 3'd0, 4'd14);
    // max sum 15+7
    step("to_max", 3'd1, 4'd15);
    step("max_plus7", 3'd7, 4'd6);
`else
    // delta=3 ladder: exact hit of 15 and of 0
    step("b3_a", 3'd3, 4'd3);
    step("b3_b", 3'd3, 4'd6);
    step("b3_c", 3'd3, 4'd9);
    step("b3_d", 3'd3, 4'd12);
    step("b3_top", 3'd3, 4'd15);
    step("b3_dn_a", 3'd3, 4'd12);
    step("b3_dn_b", 3'd3, 4'd9);
    step("b3_dn_c", 3'd3, 4'd6);
    step("b3_dn_d", 3'd3, 4'd3);
    step("b3_bottom", 3'd3, 4'd0);
    step("b3_up", 3'd3, 4'd3);
    // delta=7 ladder: reflections off both ends
    do_reset("reset_b7");
    step("b7_a", 3'd7, 4'd7);
    step("b7_b", 3'd7, 4'd14);
    step("b7_refl_top", 3'd7, 4'd9);
    step("b7_dn", 3'd7, 4'd2);
    step("b7_refl_bot", 3'd7, 4'd5);
    step("b7_up", 3'd7, 4'd12);
    step("b7_refl_top2", 3'd7, 4'd11);
    // delta=0 holds count and dir (still DOWN)
    for (int i = 0; i < 10; i++) step("hold", 3'd0, 4'd11);
    step("hold_dir_down", 3'd2, 4'd9);
    // mid-run reset then step from 0 going UP
    do_reset("mid_reset");
    step("after_reset", 3'd2, 4'd2);
    // delta changes every cycle
    step("chg_3", 3'd3, 4'd5);
    step("chg_2", 3'd2, 4'd7);
    step("chg_7", 3'd7, 4'd14);
    step("chg_0", 3'd0, 4'd14);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
